// File: rtl/systolic_job_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_job_sequencer
//
// Front-end controller for the 2x2 4-bit systolic matrix-multiply PE array.
// Collects A and B as four nibble-packed bytes, feeds the array with skewed
// operand wavefronts after a one-cycle accumulator clear, waits out the array
// latency, captures the four sums and streams them out as four beats.
//
// Optional build macro:
//   SYSTOLIC_SEQ_JOBCNT_EN - when defined, job_count counts completed jobs
//                            (saturating at 16'hFFFF); otherwise it is tied
//                            to zero and no counter register exists.
// ---------------------------------------------------------------------------
module systolic_job_sequencer #(
   parameter  int DATA_W    = 4,
   parameter  int DRAIN_CYC = 2,
   localparam int ACC_W     = 2 * DATA_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   output logic              pe_clear,
   output logic              pe_valid,
   output logic [DATA_W-1:0] pe_a0,
   output logic [DATA_W-1:0] pe_a1,
   output logic [DATA_W-1:0] pe_b0,
   output logic [DATA_W-1:0] pe_b1,
   input  logic [ACC_W-1:0]  pe_c00,
   input  logic [ACC_W-1:0]  pe_c01,
   input  logic [ACC_W-1:0]  pe_c10,
   input  logic [ACC_W-1:0]  pe_c11,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              busy,
   output logic [15:0]       job_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CLEAR   = 3'd2,
      S_FEED    = 3'd3,
      S_DRAIN   = 3'd4,
      S_CAPTURE = 3'd5,
      S_OUT     = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_nextState;

   logic [7:0]        r_beat [4];
   logic [1:0]        r_beatCnt;
   logic [1:0]        r_feedCnt;
   logic [2:0]        r_drainCnt;
   logic [ACC_W-1:0]  r_res [4];
   logic [1:0]        r_outIdx;

   logic              w_inReady;
   logic              w_inHs;
   logic              w_outHs;
   logic              w_peClear;
   logic              w_peValid;
   logic [DATA_W-1:0] w_a0;
   logic [DATA_W-1:0] w_a1;
   logic [DATA_W-1:0] w_b0;
   logic [DATA_W-1:0] w_b1;
   logic              w_outValid;
   logic [ACC_W-1:0]  w_outData;

   // Element views of the stored beats: A00/A01, A10/A11, B00/B01, B10/B11.
   // The high nibble of each byte is column 0, the low nibble column 1.
   logic [DATA_W-1:0] w_a00, w_a01, w_a10, w_a11;
   logic [DATA_W-1:0] w_b00, w_b01, w_b10, w_b11;

   assign w_a00 = r_beat[0][2*DATA_W-1:DATA_W];
   assign w_a01 = r_beat[0][DATA_W-1:0];
   assign w_a10 = r_beat[1][2*DATA_W-1:DATA_W];
   assign w_a11 = r_beat[1][DATA_W-1:0];
   assign w_b00 = r_beat[2][2*DATA_W-1:DATA_W];
   assign w_b01 = r_beat[2][DATA_W-1:0];
   assign w_b10 = r_beat[3][2*DATA_W-1:DATA_W];
   assign w_b11 = r_beat[3][DATA_W-1:0];

   // in_ready is forced low while reset is held so every output reads zero
   // during reset, even though IDLE itself advertises readiness.
   assign in_ready  = rst_n & w_inReady;
   assign w_inHs    = in_valid & in_ready;
   assign w_outHs   = w_outValid & out_ready;

   assign pe_clear  = w_peClear;
   assign pe_valid  = w_peValid;
   assign pe_a0     = w_a0;
   assign pe_a1     = w_a1;
   assign pe_b0     = w_b0;
   assign pe_b1     = w_b1;
   assign out_valid = w_outValid;
   assign out_data  = w_outData;
   assign busy      = (r_state != S_IDLE);

   // State register; an asynchronous reset abandons any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and output decode. Feed cycles present the skewed wavefront
   // so each PE sees matching A/B pairs as operands ripple right and down.
   always_comb begin
      w_nextState = r_state;
      w_inReady   = 1'b0;
      w_peClear   = 1'b0;
      w_peValid   = 1'b0;
      w_a0        = '0;
      w_a1        = '0;
      w_b0        = '0;
      w_b1        = '0;
      w_outValid  = 1'b0;
      w_outData   = '0;
      case (r_state)
         S_IDLE: begin
            w_inReady = 1'b1;
            if (in_valid) begin
               w_nextState = S_LOAD;
            end
         end
         S_LOAD: begin
            w_inReady = 1'b1;
            if (in_valid && (r_beatCnt == 2'd3)) begin
               w_nextState = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_peClear   = 1'b1;
            w_nextState = S_FEED;
         end
         S_FEED: begin
            w_peValid = 1'b1;
            case (r_feedCnt)
               2'd0: begin
                  w_a0 = w_a00;
                  w_b0 = w_b00;
               end
               2'd1: begin
                  w_a0 = w_a01;
                  w_a1 = w_a10;
                  w_b0 = w_b10;
                  w_b1 = w_b01;
               end
               default: begin
                  w_a1 = w_a11;
                  w_b1 = w_b11;
               end
            endcase
            if (r_feedCnt == 2'd2) begin
               w_nextState = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_drainCnt == 3'(DRAIN_CYC - 1)) begin
               w_nextState = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            w_nextState = S_OUT;
         end
         S_OUT: begin
            w_outValid = 1'b1;
            w_outData  = r_res[r_outIdx];
            if (out_ready && (r_outIdx == 2'd3)) begin
               w_nextState = S_IDLE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Input beat storage; the beat counter orders A row0, A row1, B row0,
   // B row1 and is held at zero outside the loading states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beatCnt <= '0;
         for (int i = 0; i < 4; i++) begin
            r_beat[i] <= '0;
         end
      end else if ((r_state != S_IDLE) && (r_state != S_LOAD)) begin
         r_beatCnt <= '0;
      end else if (w_inHs) begin
         r_beat[r_beatCnt] <= in_data;
         r_beatCnt         <= r_beatCnt + 2'd1;
      end
   end

   // Feed and drain cycle counters, each running only in its own state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_feedCnt  <= '0;
         r_drainCnt <= '0;
      end else begin
         r_feedCnt  <= (r_state == S_FEED)  ? r_feedCnt + 2'd1  : 2'd0;
         r_drainCnt <= (r_state == S_DRAIN) ? r_drainCnt + 3'd1 : 3'd0;
      end
   end

   // Snapshot of the array accumulators, taken once per job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_res[i] <= '0;
         end
      end else if (r_state == S_CAPTURE) begin
         r_res[0] <= pe_c00;
         r_res[1] <= pe_c01;
         r_res[2] <= pe_c10;
         r_res[3] <= pe_c11;
      end
   end

   // Output beat index advances only on a handshake so data holds under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outIdx <= '0;
      end else if (r_state != S_OUT) begin
         r_outIdx <= '0;
      end else if (w_outHs) begin
         r_outIdx <= r_outIdx + 2'd1;
      end
   end

`ifdef SYSTOLIC_SEQ_JOBCNT_EN
   logic        w_jobDone;
   logic [15:0] r_jobCount;

   assign w_jobDone = w_outHs && (r_outIdx == 2'd3);
   assign job_count = r_jobCount;

   // Completed-job counter, bumped on the final result handshake, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_jobCount <= '0;
      end else if (w_jobDone && (r_jobCount != 16'hFFFF)) begin
         r_jobCount <= r_jobCount + 16'd1;
      end
   end
`else
   assign job_count = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_systolic_job_sequencer
//
// Directed bench for systolic_job_sequencer with a behavioural 2x2 PE array
// attached. Expected results are hand-computed matrix products.
// ---------------------------------------------------------------------------
module tb_systolic_job_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       pe_clear;
   logic       pe_valid;
   logic [3:0] pe_a0, pe_a1, pe_b0, pe_b1;
   logic [8:0] mC00, mC01, mC10, mC11;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_data;
   logic       busy;
   logic [15:0] job_count;

   int nCompared;
   int nMismatched;

   systolic_job_sequencer #(.DATA_W(4), .DRAIN_CYC(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .pe_clear  (pe_clear),
      .pe_valid  (pe_valid),
      .pe_a0     (pe_a0),
      .pe_a1     (pe_a1),
      .pe_b0     (pe_b0),
      .pe_b1     (pe_b1),
      .pe_c00    (mC00),
      .pe_c01    (mC01),
      .pe_c10    (mC10),
      .pe_c11    (mC11),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .job_count (job_count)
   );

   // 100 MHz style free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PE array: A moves right, B moves down one register per cycle,
   // each PE accumulates its product; zero operands add nothing.
   logic [3:0] mA00r, mB00r, mA10r, mB01r;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mA00r <= '0;
         mB00r <= '0;
         mA10r <= '0;
         mB01r <= '0;
         mC00  <= '0;
         mC01  <= '0;
         mC10  <= '0;
         mC11  <= '0;
      end else begin
         mA00r <= pe_a0;
         mB00r <= pe_b0;
         mA10r <= pe_a1;
         mB01r <= pe_b1;
         if (pe_clear) begin
            mC00 <= '0;
            mC01 <= '0;
            mC10 <= '0;
            mC11 <= '0;
         end else begin
            mC00 <= mC00 + 9'(pe_a0) * 9'(pe_b0);
            mC01 <= mC01 + 9'(mA00r) * 9'(pe_b1);
            mC10 <= mC10 + 9'(pe_a1) * 9'(mB00r);
            mC11 <= mC11 + 9'(mA10r) * 9'(mB01r);
         end
      end
   end

   // Drive one input beat starting at a falling edge; returns at the falling
   // edge after the handshake.
   task automatic applyStimulus(input logic [7:0] b, input string name);
      int cnt;
      in_valid = 1'b1;
      in_data  = b;
      cnt = 0;
      while (!in_ready && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 50) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL %s_in_ready_timeout: got in_ready=0 expected 1 within 50 cycles", name);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic sendJob(input logic [7:0] b0, b1, b2, b3, input string name);
      applyStimulus(b0, name);
      applyStimulus(b1, name);
      applyStimulus(b2, name);
      applyStimulus(b3, name);
   endtask

   // Accept four result beats with out_ready held high and compare each one.
   task automatic checkOutput(input logic [8:0] e0, e1, e2, e3, input string name);
      logic [8:0] exp [4];
      int cnt;
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      out_ready = 1'b1;
      cnt = 0;
      while (!out_valid && cnt < 60) begin
         @(negedge clk);
         cnt++;
      end
      nCompared++;
      if (out_valid !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL %s_out_valid_timeout: got out_valid=%b expected 1", name, out_valid);
      end else begin
         for (int k = 0; k < 4; k++) begin
            nCompared++;
            if (out_valid !== 1'b1 || out_data !== exp[k]) begin
               nMismatched++;
               $display("[TB] FAIL %s_beat%0d: got valid=%b data=%0d expected valid=1 data=%0d",
                        name, k, out_valid, out_data, exp[k]);
            end
            @(negedge clk);
         end
         nCompared++;
         if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL %s_out_valid_drop: got %b expected 0", name, out_valid);
         end
      end
   endtask

   task automatic applyReset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Reset state: every output low while held, then IDLE advertises ready.
   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      nCompared++;
      if ({in_ready, pe_clear, pe_valid, out_valid, busy} !== 5'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                  {in_ready, pe_clear, pe_valid, out_valid, busy});
      end
      nCompared++;
      if ({pe_a0, pe_a1, pe_b0, pe_b1, out_data, job_count} !== 41'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_data: got %h expected 0",
                  {pe_a0, pe_a1, pe_b0, pe_b1, out_data, job_count});
      end
      rst_n = 1'b1;
      @(negedge clk);
      nCompared++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_idle: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
      end
   endtask

   // Basic job with cycle-accurate wavefront and latency checks.
   task automatic test_basic();
      logic [15:0] expFeed [3];
      expFeed[0] = 16'h1050;
      expFeed[1] = 16'h2376;
      expFeed[2] = 16'h0408;
      sendJob(8'h12, 8'h34, 8'h56, 8'h78, "basic");
      nCompared++;
      if ({pe_clear, pe_valid, in_ready, busy} !== 4'b1001) begin
         nMismatched++;
         $display("[TB] FAIL basic_clear: got clear/valid/ready/busy=%b expected 1001",
                  {pe_clear, pe_valid, in_ready, busy});
      end
      for (int f = 0; f < 3; f++) begin
         @(negedge clk);
         nCompared++;
         if (pe_valid !== 1'b1 || pe_clear !== 1'b0 || {pe_a0, pe_a1, pe_b0, pe_b1} !== expFeed[f]) begin
            nMismatched++;
            $display("[TB] FAIL basic_feed%0d: got valid=%b ops=%h expected valid=1 ops=%h",
                     f, pe_valid, {pe_a0, pe_a1, pe_b0, pe_b1}, expFeed[f]);
         end
      end
      for (int d = 0; d < 2; d++) begin
         @(negedge clk);
         nCompared++;
         if (pe_valid !== 1'b0 || {pe_a0, pe_a1, pe_b0, pe_b1} !== 16'h0) begin
            nMismatched++;
            $display("[TB] FAIL basic_drain%0d: got valid=%b ops=%h expected valid=0 ops=0000",
                     d, pe_valid, {pe_a0, pe_a1, pe_b0, pe_b1});
         end
      end
      @(negedge clk);
      nCompared++;
      if (out_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL basic_capture: got out_valid=%b expected 0", out_valid);
      end
      @(negedge clk);
      nCompared++;
      if (out_valid !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL basic_latency: got out_valid=%b expected 1 after 7 cycles", out_valid);
      end
      checkOutput(9'd19, 9'd22, 9'd43, 9'd50, "basic");
      nCompared++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL basic_idle: got busy=%b in_ready=%b expected 0 1", busy, in_ready);
      end
   endtask

   // All elements 15: every sum is 450, which needs the full 9 bits.
   task automatic test_max_values();
      sendJob(8'hFF, 8'hFF, 8'hFF, 8'hFF, "max");
      checkOutput(9'd450, 9'd450, 9'd450, 9'd450, "max");
   endtask

   // Stall beat 1 for five cycles; data must hold and no input is accepted.
   task automatic test_backpressure();
      int cnt;
      out_ready = 1'b0;
      sendJob(8'h12, 8'h34, 8'h56, 8'h78, "bp");
      cnt = 0;
      while (!out_valid && cnt < 60) begin
         @(negedge clk);
         cnt++;
      end
      nCompared++;
      if (out_valid !== 1'b1 || out_data !== 9'd19) begin
         nMismatched++;
         $display("[TB] FAIL bp_beat0: got valid=%b data=%0d expected valid=1 data=19", out_valid, out_data);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         nCompared++;
         if (out_valid !== 1'b1 || out_data !== 9'd22 || busy !== 1'b1 || in_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_stall%0d: got valid=%b data=%0d busy=%b in_ready=%b expected 1 22 1 0",
                     s, out_valid, out_data, busy, in_ready);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      nCompared++;
      if (out_data !== 9'd43) begin
         nMismatched++;
         $display("[TB] FAIL bp_beat2: got %0d expected 43", out_data);
      end
      @(negedge clk);
      nCompared++;
      if (out_data !== 9'd50) begin
         nMismatched++;
         $display("[TB] FAIL bp_beat3: got %0d expected 50", out_data);
      end
      @(negedge clk);
      nCompared++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL bp_done: got valid=%b busy=%b expected 0 0", out_valid, busy);
      end
   endtask

   // in_valid pattern 1,0,0,1,0,1,1 with junk on idle cycles.
   task automatic test_input_gaps();
      logic [6:0] pat;
      logic [7:0] beats [4];
      int k;
      pat = 7'b1101001;
      beats[0] = 8'h12; beats[1] = 8'h34; beats[2] = 8'h56; beats[3] = 8'h78;
      k = 0;
      for (int i = 0; i < 7; i++) begin
         in_valid = pat[i];
         in_data  = pat[i] ? beats[k] : 8'hEE;
         @(negedge clk);
         if (pat[i]) k++;
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
      nCompared++;
      if (pe_clear !== 1'b1 || in_ready !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL gaps_clear: got pe_clear=%b in_ready=%b expected 1 0", pe_clear, in_ready);
      end
      checkOutput(9'd19, 9'd22, 9'd43, 9'd50, "gaps");
   endtask

   // Reset asserted in feed cycle f1; outputs drop at once, next job is clean.
   task automatic test_reset_mid_feed();
      sendJob(8'hFF, 8'hFF, 8'hFF, 8'hFF, "rstfeed");
      @(negedge clk);
      @(negedge clk);
      nCompared++;
      if (pe_valid !== 1'b1 || {pe_a0, pe_a1, pe_b0, pe_b1} !== 16'hFFFF) begin
         nMismatched++;
         $display("[TB] FAIL rstfeed_f1: got valid=%b ops=%h expected 1 ffff",
                  pe_valid, {pe_a0, pe_a1, pe_b0, pe_b1});
      end
      #1 rst_n = 1'b0;
      #1;
      nCompared++;
      if ({in_ready, pe_clear, pe_valid, out_valid, busy, pe_a0, pe_a1, pe_b0, pe_b1, out_data} !== 30'b0) begin
         nMismatched++;
         $display("[TB] FAIL rstfeed_async: got %h expected 0",
                  {in_ready, pe_clear, pe_valid, out_valid, busy, pe_a0, pe_a1, pe_b0, pe_b1, out_data});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sendJob(8'h20, 8'h13, 8'h45, 8'h67, "rstfeed_fresh");
      checkOutput(9'd8, 9'd10, 9'd22, 9'd26, "rstfeed_fresh");
   endtask

   // Three jobs back to back from a fresh reset, then the job counter.
   task automatic test_back_to_back();
      logic [15:0] expCnt;
      applyReset();
      nCompared++;
      if (job_count !== 16'd0) begin
         nMismatched++;
         $display("[TB] FAIL b2b_count_reset: got %0d expected 0", job_count);
      end
      sendJob(8'h00, 8'h00, 8'h00, 8'h00, "b2b_zero");
      checkOutput(9'd0, 9'd0, 9'd0, 9'd0, "b2b_zero");
      sendJob(8'h12, 8'h34, 8'h56, 8'h78, "b2b_basic");
      checkOutput(9'd19, 9'd22, 9'd43, 9'd50, "b2b_basic");
      sendJob(8'hFF, 8'hFF, 8'hFF, 8'hFF, "b2b_max");
      checkOutput(9'd450, 9'd450, 9'd450, 9'd450, "b2b_max");
`ifdef SYSTOLIC_SEQ_JOBCNT_EN
      expCnt = 16'd3;
`else
      expCnt = 16'd0;
`endif
      nCompared++;
      if (job_count !== expCnt) begin
         nMismatched++;
         $display("[TB] FAIL b2b_job_count: got %0d expected %0d", job_count, expCnt);
      end
   endtask

   // Test sequence.
   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = 8'h00;
      out_ready   = 1'b0;
      test_reset();
      test_basic();
      test_max_values();
      test_backpressure();
      test_input_gaps();
      test_reset_mid_feed();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
